// File: rtl/stp16_frame_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : stp16_frame_receiver                                         |
// | Description : Oversampling receiver for the STP16CPC26 serial LED bus.     |
// |               Deserializes MSB-first WIDTH-bit frames, delivers latched    |
// |               frames on a valid/ready port, flags framing and overrun.     |
// |               Optional macro STP16_RX_DEDUP_EN drops repeated frames that  |
// |               equal the last accepted frame.                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module stp16_frame_receiver #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stp16_clk,
  input  logic                          stp16_sdi,
  input  logic                          stp16_le,
  input  logic                          stp16_noe,
  output logic                          o_valid,
  input  logic                          o_ready,
  output logic [WIDTH-1:0]              o_data,
  output logic                          o_enabled,
  output logic                          o_frame_err,
  output logic                          o_overrun,
  output logic [$clog2(WIDTH+2)-1:0]    o_bit_count
);

  localparam int            CW         = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] COUNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] COUNT_MAX  = CW'(WIDTH + 1);

  // Bus bits packed together so one synchronizer chain serves all four lines:
  // [3]=noe, [2]=le, [1]=sdi, [0]=clk.
  logic [3:0]       bus_in;
  logic [3:0]       sync_q [SYNC_STAGES];
  logic [3:0]       bus_s;
  logic             clk_d;
  logic             le_d;
  logic             clk_rise;
  logic             le_rise;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] next_shreg;
  logic [CW-1:0]    count;
  logic [CW-1:0]    next_count;
  logic             is_dup;

  assign bus_in = {stp16_noe, stp16_le, stp16_sdi, stp16_clk};
  assign bus_s  = sync_q[SYNC_STAGES-1];

  // Multi-flop synchronizer for all bus inputs; sdi shares the clk stage so
  // data stays aligned with its shift edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'b0000;
    end else begin
      sync_q[0] <= bus_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // One-cycle delayed copies for rising-edge detection, plus the enable flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_d     <= 1'b0;
      le_d      <= 1'b0;
      o_enabled <= 1'b0;
    end else begin
      clk_d     <= bus_s[0];
      le_d      <= bus_s[2];
      o_enabled <= ~bus_s[3];
    end
  end

  assign clk_rise = bus_s[0] & ~clk_d;
  assign le_rise  = bus_s[2] & ~le_d;

  // Post-shift view: when clk and le rise together the final bit is included
  // in both the word and the count used for the frame check.
  assign next_shreg = clk_rise ? {shreg[WIDTH-2:0], bus_s[1]} : shreg;
  assign next_count = (clk_rise && (count != COUNT_MAX)) ? count + CW'(1) : count;

`ifdef STP16_RX_DEDUP_EN
  logic [WIDTH-1:0] last_word;
  logic             have_last;

  // Remember the last frame the consumer actually accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_word <= '0;
      have_last <= 1'b0;
    end else if (o_valid && o_ready) begin
      last_word <= o_data;
      have_last <= 1'b1;
    end
  end

  assign is_dup = have_last && (next_shreg == last_word);
`else
  assign is_dup = 1'b0;
`endif

  // Shift, count, frame check and valid/ready output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg       <= '0;
      count       <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
      if (o_valid && o_ready) o_valid <= 1'b0;
      if (clk_rise) shreg <= next_shreg;
      if (le_rise) begin
        count <= '0;
        if (next_count == COUNT_FULL) begin
          if (!is_dup) begin
            o_data  <= next_shreg;
            o_valid <= 1'b1;
            // Latest display state wins; an unaccepted frame is replaced.
            if (o_valid && !o_ready) o_overrun <= 1'b1;
          end
        end else begin
          o_frame_err <= 1'b1;
        end
      end else begin
        count <= next_count;
      end
    end
  end

  assign o_bit_count = count;

endmodule
`default_nettype wire

// File: tb/tb_stp16_frame_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_stp16_frame_receiver                                      |
// | Description : Scoreboard bench for stp16_frame_receiver (WIDTH=32).        |
// |               Honors STP16_RX_DEDUP_EN when the design is built with it.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_stp16_frame_receiver;

  localparam int WIDTH       = 32;
  localparam int SYNC_STAGES = 2;
  localparam int CW          = $clog2(WIDTH + 2);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             stp16_clk = 1'b0;
  logic             stp16_sdi = 1'b0;
  logic             stp16_le = 1'b0;
  logic             stp16_noe = 1'b1;
  logic             o_valid;
  logic             o_ready = 1'b1;
  logic [WIDTH-1:0] o_data;
  logic             o_enabled;
  logic             o_frame_err;
  logic             o_overrun;
  logic [CW-1:0]    o_bit_count;

  int n_checks = 0;
  int n_pass   = 0;
  int err_cnt  = 0;
  int ovr_cnt  = 0;
  logic [WIDTH-1:0] exp_q [$];

  stp16_frame_receiver #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .reset(reset),
    .stp16_clk(stp16_clk), .stp16_sdi(stp16_sdi),
    .stp16_le(stp16_le), .stp16_noe(stp16_noe),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
    .o_enabled(o_enabled), .o_frame_err(o_frame_err),
    .o_overrun(o_overrun), .o_bit_count(o_bit_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Output monitor: pops the scoreboard on each handshake, counts pulses.
  always @(negedge clk) begin
    if (!reset) begin
      if (o_frame_err) err_cnt++;
      if (o_overrun)   ovr_cnt++;
      if (o_valid && o_ready) begin
        if (exp_q.size() == 0) chk("spurious_frame", {32'h0, o_data}, 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("frame_data", {32'h0, o_data}, {32'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shift n bits of v MSB first; optionally raise le together with the last clk.
  task automatic send_bits(input logic [63:0] v, input int n, input bit joint);
    for (int i = n - 1; i >= 0; i--) begin
      stp16_sdi = v[i];
      wait_n(3);
      stp16_clk = 1'b1;
      if (joint && i == 0) stp16_le = 1'b1;
      wait_n(3);
      stp16_clk = 1'b0;
      stp16_le  = 1'b0;
    end
    wait_n(4);
  endtask

  task automatic le_pulse();
    stp16_le = 1'b1;
    wait_n(3);
    stp16_le = 1'b0;
    wait_n(4);
  endtask

  task automatic good_frame(input logic [31:0] v, input bit push);
    if (push) exp_q.push_back(v);
    send_bits({32'h0, v}, 32, 1'b0);
    le_pulse();
  endtask

  initial begin
    int e0;
    int o0;
    int guard;
    // Reset state
    wait_n(3);
    chk("rst_valid",   o_valid,     0);
    chk("rst_data",    o_data,      0);
    chk("rst_bitcnt",  o_bit_count, 0);
    chk("rst_enabled", o_enabled,   0);
    chk("rst_err",     o_frame_err, 0);
    chk("rst_ovr",     o_overrun,   0);
    reset = 1'b0;
    wait_n(5);
    chk("enabled_off", o_enabled, 0);

    // noe 1->0: o_enabled rises SYNC_STAGES+1 cycles later
    stp16_noe = 1'b0;
    wait_n(SYNC_STAGES);
    chk("enabled_early", o_enabled, 0);
    wait_n(1);
    chk("enabled_latency", o_enabled, 1);

    // Loopback frame with latency check
    exp_q.push_back(32'hA5C3_0F81);
    send_bits(64'hA5C3_0F81, 32, 1'b0);
    chk("bitcnt_full", o_bit_count, 32);
    stp16_le = 1'b1;
    wait_n(SYNC_STAGES);
    chk("valid_early", o_valid, 0);
    wait_n(1);
    chk("valid_latency", o_valid, 1);
    wait_n(2);
    stp16_le = 1'b0;
    wait_n(4);
    chk("no_err_good", err_cnt, 0);

    // 31 bits then le: framing error, nothing delivered
    send_bits(64'h7FFF_FFFF, 31, 1'b0);
    chk("bitcnt_31", o_bit_count, 31);
    le_pulse();
    chk("err_short", err_cnt, 1);
    chk("valid_after_short", o_valid, 0);
    chk("bitcnt_cleared", o_bit_count, 0);
    good_frame(32'h0000_0001, 1'b1);

    // 33 bits 1,0..0,1: error; then 36 bits: count saturates
    send_bits(64'h1_0000_0001, 33, 1'b0);
    chk("bitcnt_33", o_bit_count, 33);
    le_pulse();
    chk("err_long", err_cnt, 2);
    send_bits(64'hF_1234_5678, 36, 1'b0);
    chk("bitcnt_sat", o_bit_count, 33);
    le_pulse();
    chk("err_sat", err_cnt, 3);

    // Final bit and le raised together
    exp_q.push_back(32'hC001_D00D);
    send_bits(64'hC001_D00D, 32, 1'b1);
    wait_n(2);
    chk("err_joint", err_cnt, 3);

    // Overrun: two frames while not ready, latest wins
    o0 = ovr_cnt;
    o_ready = 1'b0;
    good_frame(32'h1111_1111, 1'b0);
    good_frame(32'h2222_2222, 1'b1);
    chk("overrun_once", ovr_cnt - o0, 1);
    chk("ovr_data", o_data, 32'h2222_2222);
    wait_n(5);
    chk("ovr_valid_held", o_valid, 1);
    chk("ovr_data_stable", o_data, 32'h2222_2222);
    o_ready = 1'b1;
    wait_n(2);
    chk("valid_dropped", o_valid, 0);

    // Reset mid-frame with a pending frame discarded
    o_ready = 1'b0;
    good_frame(32'h3333_3333, 1'b0);
    send_bits(64'h3FF, 10, 1'b0);
    chk("bitcnt_10", o_bit_count, 10);
    reset = 1'b1;
    wait_n(2);
    chk("midrst_valid",   o_valid,     0);
    chk("midrst_data",    o_data,      0);
    chk("midrst_bitcnt",  o_bit_count, 0);
    chk("midrst_enabled", o_enabled,   0);
    reset = 1'b0;
    o_ready = 1'b1;
    wait_n(4);
    good_frame(32'h5A5A_1234, 1'b1);

    // Repeated refresh frames, then a changed one
    e0 = err_cnt;
    good_frame(32'hDEAD_BEEF, 1'b1);
`ifdef STP16_RX_DEDUP_EN
    good_frame(32'hDEAD_BEEF, 1'b0);
    good_frame(32'hDEAD_BEEF, 1'b0);
`else
    good_frame(32'hDEAD_BEEF, 1'b1);
    good_frame(32'hDEAD_BEEF, 1'b1);
`endif
    good_frame(32'hDEAD_BEEE, 1'b1);
    chk("err_refresh", err_cnt - e0, 0);

    // Drain the scoreboard with a bounded wait
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      wait_n(1);
      guard++;
    end
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("overrun_total", ovr_cnt, 1);
    chk("err_total", err_cnt, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
